// File: rtl/button_event_if.sv
// Event interface for button_event: debounced level in, UI event pulses and hold levels out.
interface button_event_if;
  logic db_i;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic rpt_o;
  logic held_o;
  logic long_held_o;

  modport master (
    output db_i,
    input  press_o, release_o, long_press_o, rpt_o, held_o, long_held_o
  );

  modport slave (
    input  db_i,
    output press_o, release_o, long_press_o, rpt_o, held_o, long_held_o
  );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press / release / long-press pulses.
// Define BUTTON_EVENT_REPEAT_EN to add auto-repeat pulses while in long-press.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | button released, hold counter parked at 0
// PRESSED | button down, counting toward LONG_CYCLES
// LONG    | long-press reached; repeat counter runs when enabled
module button_event #(
  parameter int unsigned LONG_CYCLES   = 100000000,
  parameter int unsigned REPEAT_CYCLES = 20000000
) (
  input logic           clk,
  input logic           reset,
  button_event_if.slave bus
);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int unsigned MAX_CYCLES =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
`else
  localparam int unsigned MAX_CYCLES = LONG_CYCLES;
`endif
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
`endif

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("button_event: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    PRESSED = 3'b010,
    LONG    = 3'b100
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          db_q;
  logic          press_q;
  logic          release_q;
  logic          long_press_q;
  logic          held_q;
  logic          long_held_q;
  logic          rise;
  logic          fall;

  assign rise = bus.db_i & ~db_q;
  assign fall = ~bus.db_i & db_q;

`ifdef BUTTON_EVENT_REPEAT_EN
  logic rpt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      db_q         <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      held_q       <= 1'b0;
      long_held_q  <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt_q        <= 1'b0;
`endif
    end else begin
      db_q         <= bus.db_i;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt_q        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            // The rise sample is the first high cycle, so counting starts at 1.
            press_q <= 1'b1;
            held_q  <= 1'b1;
            cnt_q   <= CW'(1);
            state_q <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else if (bus.db_i) begin
            if (cnt_q == LONG_TC) begin
              long_press_q <= 1'b1;
              long_held_q  <= 1'b1;
              cnt_q        <= '0;
              state_q      <= LONG;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        LONG: begin
          if (fall) begin
            release_q   <= 1'b1;
            held_q      <= 1'b0;
            long_held_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (cnt_q == REPEAT_TC) begin
              rpt_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
`else
            cnt_q <= '0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          held_q      <= 1'b0;
          long_held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_o      = press_q;
  assign bus.release_o    = release_q;
  assign bus.long_press_o = long_press_q;
  assign bus.held_o       = held_q;
  assign bus.long_held_o  = long_held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
  assign bus.rpt_o        = rpt_q;
`else
  assign bus.rpt_o        = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;
  localparam int unsigned LC = 8;
  localparam int unsigned RC = 4;

  // Output vector order: {press, release, long_press, rpt, held, long_held}
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] L  = 6'b001000;
  localparam logic [5:0] T  = 6'b000100;
  localparam logic [5:0] H  = 6'b000010;
  localparam logic [5:0] LH = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  button_event_if bus ();

  button_event #(.LONG_CYCLES(LC), .REPEAT_CYCLES(RC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.press_o, bus.release_o, bus.long_press_o, bus.rpt_o,
            bus.held_o, bus.long_held_o};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive db, let one rising edge sample it, then check the registered outputs.
  task automatic tick(input string tag, input logic db_v, input logic [5:0] exp);
    bus.db_i = db_v;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  // Expected outputs after the i-th high sample of a press (i=0 is the rise).
  function automatic logic [5:0] hold_exp(input int i);
    logic [5:0] e;
    e = H;
    if (i == 0) e = e | P;
    if (i >= int'(LC) - 1) e = e | LH;
    if (i == int'(LC) - 1) e = e | L;
`ifdef BUTTON_EVENT_REPEAT_EN
    if (i >= int'(LC) && ((i - (int'(LC) - 1)) % int'(RC)) == 0) e = e | T;
`endif
    return e;
  endfunction

  task automatic press_for(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b1, hold_exp(i));
    tick({tag, "_rel"}, 1'b0, R);
    tick({tag, "_idle"}, 1'b0, 6'b0);
  endtask

  initial begin
    reset    = 1'b0;
    bus.db_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 6'b0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick("idle_quiet", 1'b0, 6'b0);

    // Short press: 3 high samples.
    press_for("short", 3);

    // Long press: 12 high samples, long_press 7 cycles after press.
    press_for("long", 12);

    // Terminal count coincides with fall: release only.
    press_for("boundary", int'(LC) - 1);

    // Extended hold exercises auto-repeat (or its absence).
    press_for("repeat", 20);

    // Async reset while in LONG, button still held.
    for (int i = 0; i < 10; i++) tick("pre_reset", 1'b1, hold_exp(i));
    reset = 1'b0;
    #1;
    check("async_reset_drop", 6'b0);
    tick("in_reset", 1'b1, 6'b0);
    tick("in_reset", 1'b1, 6'b0);
    reset = 1'b1;
    tick("post_reset_press", 1'b1, P | H);
    tick("post_reset_hold", 1'b1, H);
    tick("post_reset_rel", 1'b0, R);
    tick("post_reset_idle", 1'b0, 6'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the switch debouncer; consumes its clean level output `db`.
- Converts that level into single-cycle user-interface events: press, release and long-press.
- Control logic (menu FSMs, counters) reacts to these pulses instead of raw levels.
- Assumes `db` is already synchronous to `clk` and glitch-free.

Parameters:
- LONG_CYCLES, 100000000, cycles `db` must stay high before `long_press` fires (1 s at 10 ns clock); must be >= 2.
- REPEAT_CYCLES, 20000000, auto-repeat period once long-press is reached; used only with REPEAT_EN; must be >= 2.
- CW (localparam), $clog2(max(LONG_CYCLES, REPEAT_CYCLES)), hold-counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- db  input  1  debounced switch level, 1 = pressed.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
- rpt  output  1  one-cycle auto-repeat pulse (tied 0 without REPEAT_EN).
- held  output  1  level, 1 while button is considered pressed.
- long_held  output  1  level, 1 after `long_press` until release.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, db_q=0, all outputs 0.
- Edge detect: db_q <= db every cycle; rise = db & ~db_q; fall = ~db & db_q.
- All outputs registered. Each pulse is high for exactly the one clock period following the edge at which the triggering condition is sampled.
- State machine is one-hot, 3 states:
  - IDLE: counter=0. On rise: press=1, go PRESSED.
  - PRESSED: counter increments each cycle `db` is high.
    - counter==LONG_CYCLES-1 and db=1: long_press=1, counter<=0, go LONG.
    - fall: release=1, counter<=0, go IDLE.
  - LONG: with REPEAT_EN, counter counts 0..REPEAT_CYCLES-1.
    - At terminal count: rpt=1, counter wraps to 0.
    - fall: release=1, counter<=0, go IDLE.
- held=1 in PRESSED and LONG. long_held=1 in LONG only. Both update in the same cycle as the state register.
- Timing:
  - press occurs 1 cycle after `db` is first sampled high.
  - long_press fires when `db` has been sampled high for LONG_CYCLES consecutive cycles, counting the rise cycle as cycle 0.
  - Between press and long_press: exactly LONG_CYCLES-1 cycles.
- Simultaneous events: fall in the same cycle as a terminal count means release wins. No long_press or rpt is issued; go IDLE.
- At most one of press/release/long_press/rpt is high in any cycle.
- Counter never exceeds its terminal value. Arithmetic is unsigned CW-bit with no wrap beyond terminal.
- Button held through reset deassertion: db_q=0, so a press pulse fires on the first active cycle. This is intentional (new press).
- Reset mid-hold: state returns to IDLE immediately, and no release pulse is emitted.
- A rise seen while in PRESSED/LONG cannot occur (db_q tracks db); no special handling.

Optional Feature:
- Macro BUTTON_EVENT_REPEAT_EN.
- Defined:
  - LONG state runs the repeat counter and emits `rpt` every REPEAT_CYCLES cycles.
  - First `rpt` comes REPEAT_CYCLES cycles after `long_press`.
- Undefined:
  - Counter holds at 0 in LONG; `rpt` is constant 0.
  - REPEAT_CYCLES is ignored and excluded from CW.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4):
- Reset: reset=0 with db=0 -> all outputs 0. Release reset, hold db=0 for 20 cycles -> no pulses, held=0.
- Short press: db high for 3 cycles then low.
  - press=1 one cycle after rise.
  - held=1 for 3 cycles.
  - release=1 one cycle after fall.
  - long_press never asserted.
- Long press: db high for 12 cycles.
  - press at cycle 1; long_press at cycle 8 (7 cycles after press).
  - long_held=1 from cycle 8 until release.
  - release pulse after fall.
- Boundary: db high exactly 7 cycles, falling so the terminal count coincides with fall -> release only, no long_press, state IDLE.
- Repeat (macro defined): db held 20 cycles.
  - rpt at 4, 8 and 12 cycles after long_press.
  - Without macro: rpt stays 0.
- Async reset mid-hold: assert reset during LONG.
  - Outputs drop to 0 immediately, no release pulse.
  - Deassert with db=1 -> press pulse on first active cycle.
